// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Segment codes are active-low, bit order gfedcba.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_st_e;

endpackage

// File: rtl/seg7_decode.sv
// Single shared hex-to-segment decoder; the resource being time-multiplexed.
// A set blank flag forces every segment off.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      seg_o = HEX_SEG[nibble_i];
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan scheduler: one decoder and segment bus shared by N anodes,
// with per-slot blanking and a per-frame snapshot of the digit values.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  iEn,
  input  logic [4*N_DIGITS-1:0] iDigits,
  input  logic [N_DIGITS-1:0]   iDpMask,
  input  logic                  iLzb,
  output logic [N_DIGITS-1:0]   oAn,
  output logic [6:0]            oSeg,
  output logic                  oDp,
  output logic [IDX_W-1:0]      oScanIdx,
  output logic                  oFrame
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST =
    CNT_W'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF = '1;

  scan_st_e              state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  logic [4*N_DIGITS-1:0] snap_dig_q;
  logic [N_DIGITS-1:0]   snap_dp_q;
  logic                  snap_lzb_q;

  logic [N_DIGITS-1:0]   an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  frame_q;

  logic [N_DIGITS-1:0]   lz_mask;
  logic                  zero_tail;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [6:0]            dec_seg;

  // A digit is blanked when it and every more-significant digit is zero.
  always_comb begin
    lz_mask   = '0;
    zero_tail = 1'b1;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_tail  = zero_tail & (snap_dig_q[4*k +: 4] == 4'h0);
      lz_mask[k] = snap_lzb_q & zero_tail & (k != 0);
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = snap_dig_q[4*k +: 4];
        cur_dp  = snap_dp_q[k];
        cur_lz  = lz_mask[k];
      end
    end
  end

  assign idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  seg7_decode u_dec (
    .nibble_i (cur_nib),
    .blank_i  (cur_lz),
    .seg_o    (dec_seg)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_lzb_q <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iEn) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_dig_q <= iDigits;
            snap_dp_q  <= iDpMask;
            snap_lzb_q <= iLzb;
            frame_q    <= 1'b1;
          end
        end
        BLANK: begin
          if (!iEn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else if (cnt_q == BLANK_LAST) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            an_q    <= ~(N_DIGITS'(1) << idx_q);
            seg_q   <= dec_seg;
            dp_q    <= ~cur_dp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (!iEn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
          end else if (cnt_q == SHOW_LAST) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= idx_d;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            if (idx_d == '0) begin
              snap_dig_q <= iDigits;
              snap_dp_q  <= iDpMask;
              snap_lzb_q <= iLzb;
              frame_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          an_q    <= AN_OFF;
          seg_q   <= SEG_OFF;
          dp_q    <= 1'b1;
        end
      endcase
    end
  end

  assign oAn      = an_q;
  assign oSeg     = seg_q;
  assign oDp      = dp_q;
  assign oScanIdx = idx_q;
  assign oFrame   = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Outputs are sampled on the falling clock edge.
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        iEn = 1'b0;
  logic [15:0] iDigits = '0;
  logic [3:0]  iDpMask = '0;
  logic        iLzb = 1'b0;
  logic [3:0]  oAn;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [1:0]  oScanIdx;
  logic        oFrame;

  int n_chk = 0;
  int n_err = 0;

  seg_scan_ctrl #(
    .N_DIGITS     (4),
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .iEn      (iEn),
    .iDigits  (iDigits),
    .iDpMask  (iDpMask),
    .iLzb     (iLzb),
    .oAn      (oAn),
    .oSeg     (oSeg),
    .oDp      (oDp),
    .oScanIdx (oScanIdx),
    .oFrame   (oFrame)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at the first sample of a slot; leaves at the next slot's first.
  task automatic chk_slot(input string tag, input logic [1:0] idx,
                          input logic [6:0] seg, input logic dp);
    logic [3:0] an;
    an = ~(4'b0001 << idx);
    for (int c = 0; c < 8; c++) begin
      if (c < 2)
        chk({tag, "_blk"}, {oAn, oSeg, oDp}, {4'hF, 7'h7F, 1'b1});
      else
        chk({tag, "_show"}, {oAn, oSeg, oDp}, {an, seg, dp});
      chk({tag, "_idx"}, oScanIdx, idx);
      chk({tag, "_frm"}, oFrame, (c == 0 && idx == 2'd0));
      @(negedge CLK);
    end
  endtask

  initial begin
    int         blank_run;
    bit         seen;
    logic [3:0] prev_an;

    repeat (3) @(negedge CLK);
    chk("rst_out", {oAn, oSeg, oDp, oScanIdx, oFrame},
        {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      chk("idle", {oAn, oSeg, oDp, oFrame}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end

    // basic scan: frame 0 and frame 1
    iDigits = 16'h3A81;
    iDpMask = 4'b0100;
    iEn     = 1'b1;
    @(negedge CLK);
    chk_slot("f0s0", 2'd0, 7'h79, 1'b1);
    chk_slot("f0s1", 2'd1, 7'h00, 1'b1);
    chk_slot("f0s2", 2'd2, 7'h08, 1'b0);
    chk_slot("f0s3", 2'd3, 7'h30, 1'b1);
    chk_slot("f1s0", 2'd0, 7'h79, 1'b1);
    iDigits = 16'hFFFF;
    chk_slot("snap1", 2'd1, 7'h00, 1'b1);
    chk_slot("snap2", 2'd2, 7'h08, 1'b0);
    chk_slot("snap3", 2'd3, 7'h30, 1'b1);
    chk_slot("ff0", 2'd0, 7'h0E, 1'b1);
    chk_slot("ff1", 2'd1, 7'h0E, 1'b1);
    chk_slot("ff2", 2'd2, 7'h0E, 1'b0);
    chk_slot("ff3", 2'd3, 7'h0E, 1'b1);

    // leading-zero blanking
    iDigits = 16'h0005;
    iLzb    = 1'b1;
    iDpMask = 4'b0000;
    repeat (32) @(negedge CLK);
    chk_slot("lz5_0", 2'd0, 7'h12, 1'b1);
    chk_slot("lz5_1", 2'd1, 7'h7F, 1'b1);
    chk_slot("lz5_2", 2'd2, 7'h7F, 1'b1);
    chk_slot("lz5_3", 2'd3, 7'h7F, 1'b1);
    iDigits = 16'h0000;
    repeat (32) @(negedge CLK);
    chk_slot("lz0_0", 2'd0, 7'h40, 1'b1);
    chk_slot("lz0_1", 2'd1, 7'h7F, 1'b1);
    chk_slot("lz0_2", 2'd2, 7'h7F, 1'b1);
    chk_slot("lz0_3", 2'd3, 7'h7F, 1'b1);
    iDigits = 16'h0500;
    repeat (32) @(negedge CLK);
    chk_slot("lzm_0", 2'd0, 7'h40, 1'b1);
    chk_slot("lzm_1", 2'd1, 7'h40, 1'b1);
    chk_slot("lzm_2", 2'd2, 7'h12, 1'b1);
    chk_slot("lzm_3", 2'd3, 7'h7F, 1'b1);

    // disable mid-slot
    iDigits = 16'h3A81;
    iDpMask = 4'b0100;
    iLzb    = 1'b0;
    repeat (32) @(negedge CLK);
    repeat (19) @(negedge CLK);
    chk("dis_pre", {oAn, oSeg, oDp}, {4'b1011, 7'h08, 1'b0});
    iEn = 1'b0;
    @(negedge CLK);
    chk("dis_out", {oAn, oSeg, oDp, oScanIdx, oFrame},
        {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    repeat (5) @(negedge CLK);
    chk("dis_hold", {oAn, oSeg, oDp, oScanIdx, oFrame},
        {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    iEn = 1'b1;
    @(negedge CLK);
    chk_slot("ren0", 2'd0, 7'h79, 1'b1);

    // asynchronous reset mid-SHOW
    repeat (3) @(negedge CLK);
    chk("ars_pre", oAn, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    chk("ars_out", {oAn, oSeg, oDp, oScanIdx, oFrame},
        {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    @(negedge CLK);
    rst_n = 1'b1;

    // overlap / gap monitor over random digits
    blank_run = 0;
    seen      = 1'b0;
    prev_an   = 4'hF;
    for (int i = 0; i < 1000; i++) begin
      if (i % 7 == 0) begin
        iDigits = 16'($urandom);
        iDpMask = 4'($urandom);
        iLzb    = 1'($urandom);
      end
      @(negedge CLK);
      chk("onehot", 32'($countones(~oAn) <= 1), 32'd1);
      if (oAn == 4'hF) begin
        blank_run++;
      end else begin
        if (oAn != prev_an) begin
          if (seen) chk("gap", 32'(blank_run >= 2), 32'd1);
          seen = 1'b1;
        end
        blank_run = 0;
      end
      prev_an = oAn;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
